// File: rtl/user_project_gpio_ctrl_if.sv
// Wishbone classic slave bus between the Caravel management SoC and the GPIO controller.
interface user_project_gpio_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_project_gpio_ctrl.sv
// Wishbone GPIO controller: output/direction registers, set/clear/toggle, synchronised
// inputs and sticky per-pin edge interrupts aggregated onto irq_o.
module user_project_gpio_ctrl #(
  parameter int unsigned NUM_IO      = 38,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  user_project_gpio_ctrl_if.slave wb,
  input  logic [NUM_IO-1:0]      io_in,
  output logic [NUM_IO-1:0]      io_out,
  output logic [NUM_IO-1:0]      io_oeb,
  output logic                   irq_o
);

  logic              req, wr, rd, bank;
  logic [4:0]        idx;
  logic [31:0]       bmask, rdata;
  logic [63:0]       wmask, wdat, wbits, rd64;
  logic [63:0]       out_nx, oeb_nx, rise_nx, fall_nx, stat_nx;
  logic [NUM_IO-1:0] out_q, oeb_q, rise_q, fall_q, stat_q;
  logic [NUM_IO-1:0] sync_p [SYNC_STAGES];
  logic [NUM_IO-1:0] in_s, in_d_p, evt;
  logic              ack_q, irq_q;
  logic [31:0]       dat_q;
  logic              unused_adr;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [63:0] m);
    return (old & ~m) | (d & m);
  endfunction

  assign req  = wb.wbs_stb_i & wb.wbs_cyc_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr   = req & ~ack_q & wb.wbs_we_i;
  assign rd   = req & ~ack_q & ~wb.wbs_we_i;
  assign idx  = wb.wbs_adr_i[7:3];
  assign bank = wb.wbs_adr_i[2];
  assign unused_adr = ^wb.wbs_adr_i[1:0];

  assign in_s = sync_p[SYNC_STAGES-1];
  assign evt  = (in_s & ~in_d_p & rise_q) | (~in_s & in_d_p & fall_q);

  always_comb begin
    for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{wb.wbs_sel_i[i]}};
    wmask   = bank ? {bmask, 32'h0} : {32'h0, bmask};
    wdat    = bank ? {wb.wbs_dat_i, 32'h0} : {32'h0, wb.wbs_dat_i};
    wbits   = wdat & wmask;
    out_nx  = 64'(out_q);
    oeb_nx  = 64'(oeb_q);
    rise_nx = 64'(rise_q);
    fall_nx = 64'(fall_q);
    stat_nx = 64'(stat_q);
    if (wr) begin
      case (idx)
        5'd0:    out_nx  = merge(out_nx, wdat, wmask);
        5'd1:    oeb_nx  = merge(oeb_nx, wdat, wmask);
        5'd3:    out_nx  = out_nx | wbits;
        5'd4:    out_nx  = out_nx & ~wbits;
        5'd5:    out_nx  = out_nx ^ wbits;
        5'd6:    rise_nx = merge(rise_nx, wdat, wmask);
        5'd7:    fall_nx = merge(fall_nx, wdat, wmask);
        5'd8:    stat_nx = stat_nx & ~wbits;
        default: ;
      endcase
    end
    // New edge events are ORed in after the W1C so a coincident set wins.
    stat_nx = stat_nx | 64'(evt);
    case (idx)
      5'd0:    rd64 = 64'(out_q);
      5'd1:    rd64 = 64'(oeb_q);
      5'd2:    rd64 = 64'(in_s);
      5'd6:    rd64 = 64'(rise_q);
      5'd7:    rd64 = 64'(fall_q);
      5'd8:    rd64 = 64'(stat_q);
      default: rd64 = 64'h0;
    endcase
    rdata = bank ? rd64[63:32] : rd64[31:0];
  end

  // Stage boundary: synchroniser chain, edge-detect delay, register file and bus outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_p[i] <= '0;
      in_d_p <= '0;
      out_q  <= '0;
      oeb_q  <= '1;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync_p[0] <= io_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_p[i] <= sync_p[i-1];
      in_d_p <= in_s;
      out_q  <= NUM_IO'(out_nx);
      oeb_q  <= NUM_IO'(oeb_nx);
      rise_q <= NUM_IO'(rise_nx);
      fall_q <= NUM_IO'(fall_nx);
      stat_q <= NUM_IO'(stat_nx);
      ack_q  <= req & ~ack_q;
      if (rd) dat_q <= rdata;
      irq_q  <= |stat_q;
    end
  end

  assign io_out       = out_q;
  assign io_oeb       = oeb_q;
  assign irq_o        = irq_q;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_user_project_gpio_ctrl.sv
// Bench for user_project_gpio_ctrl: directed vector table, hand-timed corner sequences,
// then random register traffic and pin activity against a bit-level reference model.
module tb_user_project_gpio_ctrl;
  localparam int N = 38;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] io_in, io_out, io_oeb;
  logic         irq_o;
  int           checks = 0;
  int           errors = 0;

  user_project_gpio_ctrl_if bus();

  user_project_gpio_ctrl #(.NUM_IO(N), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (bus),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  // Reference model: one bit per pin, registers indexed by pin number.
  logic [63:0] m_out, m_oeb, m_rise, m_fall, m_stat, m_in;

  task automatic m_reset();
    m_out = '0; m_oeb = '0; m_rise = '0; m_fall = '0; m_stat = '0; m_in = '0;
    for (int p = 0; p < N; p++) m_oeb[p] = 1'b1;
  endtask

  task automatic m_write(input int ri, input int bk, input logic [3:0] s, input logic [31:0] d);
    for (int b = 0; b < 32; b++) begin
      int p;
      p = bk * 32 + b;
      if (s[b/8] && p < N) begin
        case (ri)
          0: m_out[p] = d[b];
          1: m_oeb[p] = d[b];
          3: if (d[b]) m_out[p] = 1'b1;
          4: if (d[b]) m_out[p] = 1'b0;
          5: if (d[b]) m_out[p] = ~m_out[p];
          6: m_rise[p] = d[b];
          7: m_fall[p] = d[b];
          8: if (d[b]) m_stat[p] = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [31:0] m_read(input int ri, input int bk);
    logic [31:0] v;
    v = '0;
    for (int b = 0; b < 32; b++) begin
      int p;
      p = bk * 32 + b;
      if (p < N) begin
        case (ri)
          0: v[b] = m_out[p];
          1: v[b] = m_oeb[p];
          2: v[b] = m_in[p];
          6: v[b] = m_rise[p];
          7: v[b] = m_fall[p];
          8: v[b] = m_stat[p];
          default: v[b] = 1'b0;
        endcase
      end
    end
    return v;
  endfunction

  task automatic m_pin(input logic [N-1:0] nv);
    for (int p = 0; p < N; p++) begin
      if (nv[p] && !m_in[p] && m_rise[p]) m_stat[p] = 1'b1;
      if (!nv[p] && m_in[p] && m_fall[p]) m_stat[p] = 1'b1;
    end
    m_in = 64'(nv);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
  endtask

  task automatic bus_req(input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = w;
    bus.wbs_sel_i = s;    bus.wbs_adr_i = a;    bus.wbs_dat_i = d;
  endtask

  task automatic xfer(input bit w, input logic [7:0] off, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    bus_req(w, BASE | 32'(off), s, d);
    @(posedge clk); #1;
    chk($sformatf("ack_latency off=%0h", off), 64'(bus.wbs_ack_o), 64'd1);
    r = bus.wbs_dat_o;
    @(negedge clk);
    bus_idle();
  endtask

  typedef struct {
    bit        we;
    bit [7:0]  off;
    bit [3:0]  sel;
    bit [31:0] dat;
    bit [31:0] exp;   // read data for reads, io_out[31:0] after writes
  } vec_t;

  vec_t tbl[40];
  int   nv = 0;

  task automatic add_vec(input bit w, input bit [7:0] o, input bit [3:0] s,
                         input bit [31:0] d, input bit [31:0] e);
    tbl[nv].we = w; tbl[nv].off = o; tbl[nv].sel = s; tbl[nv].dat = d; tbl[nv].exp = e;
    nv++;
  endtask

  initial begin
    logic [31:0]  r;
    logic [N-1:0] pins;

    for (int o = 0; o < 'h48; o += 4)
      add_vec(0, 8'(o), 4'hF, 32'h0, (o == 'h08) ? 32'hFFFF_FFFF : (o == 'h0C) ? 32'h3F : 32'h0);
    add_vec(1, 8'h00, 4'hF, 32'h0000_00AA, 32'h0000_00AA);
    add_vec(1, 8'h18, 4'hF, 32'h0000_0100, 32'h0000_01AA);
    add_vec(1, 8'h20, 4'hF, 32'h0000_0002, 32'h0000_01A8);
    add_vec(1, 8'h28, 4'hF, 32'h0000_0081, 32'h0000_0129);
    add_vec(0, 8'h00, 4'hF, 32'h0,         32'h0000_0129);
    add_vec(1, 8'h04, 4'h1, 32'hFFFF_FFFF, 32'h0000_0129);
    add_vec(0, 8'h04, 4'hF, 32'h0,         32'h0000_003F);
    add_vec(1, 8'h18, 4'h2, 32'h0000_0303, 32'h0000_0329);
    add_vec(1, 8'h20, 4'h1, 32'h0000_0300, 32'h0000_0329);
    add_vec(0, 8'h18, 4'hF, 32'h0,         32'h0);
    add_vec(0, 8'h80, 4'hF, 32'h0,         32'h0);
    add_vec(1, 8'h80, 4'hF, 32'hFFFF_FFFF, 32'h0000_0329);
    add_vec(0, 8'hFC, 4'hF, 32'h0,         32'h0);
    add_vec(0, 8'h00, 4'hF, 32'h0,         32'h0000_0329);

    rst_n = 1'b0;
    io_in = '0;
    pins  = '0;
    bus_idle();
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_io_oeb", 64'(io_oeb), m_oeb);
    chk("rst_io_out", 64'(io_out), 64'h0);
    chk("rst_irq", 64'(irq_o), 64'h0);
    chk("rst_ack", 64'(bus.wbs_ack_o), 64'h0);
    chk("rst_dat", 64'(bus.wbs_dat_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      xfer(tbl[i].we, tbl[i].off, tbl[i].sel, tbl[i].dat, r);
      if (tbl[i].we) begin
        m_write(int'(tbl[i].off[7:3]), int'(tbl[i].off[2]), tbl[i].sel, tbl[i].dat);
        chk($sformatf("vec%0d io_out", i), 64'(io_out[31:0]), 64'(tbl[i].exp));
      end else begin
        chk($sformatf("vec%0d rdata", i), 64'(r), 64'(tbl[i].exp));
      end
    end
    chk("io_out_hi", 64'(io_out[37:32]), 64'h3F);

    // Held request: ack toggles every other edge.
    @(negedge clk);
    bus_req(0, BASE | 32'h08, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack%0d", k), 64'(bus.wbs_ack_o), (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    chk("b2b_rdata", 64'(bus.wbs_dat_o), 64'hFFFF_FFFF);
    @(negedge clk);
    bus_idle();

    // Outside the decode window: never acked, no write effect.
    @(negedge clk);
    bus_req(1, BASE + 32'h100, 4'hF, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("nodec_ack%0d", k), 64'(bus.wbs_ack_o), 64'h0);
    end
    @(negedge clk);
    bus_idle();
    chk("nodec_io_out", 64'(io_out), m_out);

    // Rising edge on pin 3 -> IRQ_STAT set at edge 3, irq_o at edge 4; W1C drops it.
    xfer(1, 8'h30, 4'hF, 32'h8, r);
    m_write(6, 0, 4'hF, 32'h8);
    @(negedge clk);
    pins[3] = 1'b1;
    io_in = pins;
    m_pin(pins);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("irq_edge%0d", k), 64'(irq_o), (k >= 4) ? 64'd1 : 64'd0);
    end
    xfer(0, 8'h40, 4'hF, 32'h0, r);
    chk("stat_after_rise", 64'(r), 64'(m_read(8, 0)));
    xfer(1, 8'h40, 4'hF, 32'h8, r);
    m_write(8, 0, 4'hF, 32'h8);
    @(posedge clk); #1;
    chk("irq_after_w1c", 64'(irq_o), 64'h0);

    // Fall on pin 5 lands on the same edge as a W1C of bit 5: the flag must survive.
    xfer(1, 8'h30, 4'hF, 32'h28, r);
    m_write(6, 0, 4'hF, 32'h28);
    xfer(1, 8'h38, 4'hF, 32'h20, r);
    m_write(7, 0, 4'hF, 32'h20);
    @(negedge clk);
    pins[5] = 1'b1;
    io_in = pins;
    m_pin(pins);
    repeat (5) @(posedge clk);
    @(negedge clk);
    pins[5] = 1'b0;
    io_in = pins;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus_req(1, BASE | 32'h40, 4'hF, 32'h20);
    @(posedge clk); #1;
    chk("collide_ack", 64'(bus.wbs_ack_o), 64'd1);
    m_write(8, 0, 4'hF, 32'h20);
    m_pin(pins);
    @(negedge clk);
    bus_idle();
    xfer(0, 8'h40, 4'hF, 32'h0, r);
    chk("collide_stat", 64'(r), 64'(m_read(8, 0)));
    chk("collide_bit5", 64'(r[5]), 64'd1);

    // Reset while a read ack is high: ack drops without a clock edge.
    pins = '0;
    io_in = pins;
    @(negedge clk);
    bus_req(0, BASE | 32'h00, 4'hF, 32'h0);
    @(posedge clk); #1;
    chk("pre_rst_ack", 64'(bus.wbs_ack_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", 64'(bus.wbs_ack_o), 64'h0);
    chk("async_rst_oeb", 64'(io_oeb), {26'h0, {N{1'b1}}});
    chk("async_rst_out", 64'(io_out), 64'h0);
    chk("async_rst_irq", 64'(irq_o), 64'h0);
    bus_idle();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 8'h08, 4'hF, 32'h0, r);
    chk("reissue_rdata", 64'(r), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("reissue_ack_single", 64'(bus.wbs_ack_o), 64'h0);

    // Random register traffic and pin activity.
    for (int it = 0; it < 250; it++) begin
      int op, ri, bk;
      logic [3:0]  s;
      logic [31:0] d;
      logic [7:0]  off;
      @(posedge clk); #1;
      chk($sformatf("rnd%0d irq", it), 64'(irq_o), 64'(|m_stat));
      op = $urandom_range(0, 9);
      if (op == 9) begin
        @(negedge clk);
        pins = pins ^ N'({$urandom, $urandom} & {$urandom, $urandom});
        io_in = pins;
        m_pin(pins);
        repeat (5) @(posedge clk);
      end else begin
        ri = $urandom_range(0, 11);
        if (ri > 8) ri = $urandom_range(9, 31);
        bk  = $urandom_range(0, 1);
        s   = 4'($urandom_range(0, 15));
        d   = $urandom;
        off = {5'(ri), 1'(bk), 2'($urandom_range(0, 3))};
        if (op < 6) begin
          xfer(1, off, s, d, r);
          m_write(ri, bk, s, d);
          chk($sformatf("rnd%0d io_out", it), 64'(io_out), m_out);
          chk($sformatf("rnd%0d io_oeb", it), 64'(io_oeb), m_oeb);
        end else begin
          xfer(0, off, 4'hF, 32'h0, r);
          chk($sformatf("rnd%0d rd off=%0h", it, off), 64'(r), 64'(m_read(ri, bk)));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/user_project_gpio_ctrl.md
# user_project_gpio_ctrl

Parametrised Wishbone-slave GPIO controller for the user project area, the next generation of our fixed 38-pin GPIO example. It provides per-pin output data and direction, atomic set/clear/toggle, synchronised input sampling, and per-pin rising/falling edge interrupts with sticky status. It sits between the Caravel management Wishbone bus and the `MPRJ_IO` pads, and raises one aggregated interrupt line to the management SoC.

## Interface
- `NUM_IO`, 38: number of pins; legal range 1..64; each register spans two 32-bit banks (bits 31:0, 63:32).
- `BASE_ADDR`, 32'h3000_0000: slave base; decode on `wbs_adr_i[31:8] == BASE_ADDR[31:8]`.
- `SYNC_STAGES`, 2: input synchroniser depth; legal range 2..4.
- `wb_clk_i` in 1: single clock for all logic.
- `wb_rst_n_i` in 1: asynchronous, active-low reset.
- `wbs_stb_i` / `wbs_cyc_i` / `wbs_we_i` in 1: Wishbone classic strobe, cycle, write enable.
- `wbs_sel_i` in 4: byte enables for writes.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `wbs_dat_o` out 32: registered read data.
- `io_in` in NUM_IO: pad inputs, asynchronous to `wb_clk_i`.
- `io_out` out NUM_IO: pad output data.
- `io_oeb` out NUM_IO: pad output enable, active-low (1 = input).
- `irq_o` out 1: registered OR of all `IRQ_STAT` bits.

## Operation
- Address: offset = `adr[7:0]`; register index r = offset[7:3], bank = offset[2] (0: bits 31:0, 1: bits 63:32). `adr[1:0]` ignored.
- r0 `OUT` RW: drives `io_out`. r1 `OEB` RW: drives `io_oeb`. r2 `IN` RO: last synchroniser stage.
- r3 `SET` / r4 `CLR` / r5 `TGL` WO: each 1 bit sets/clears/inverts the matching `OUT` bit; read as 0.
- r6 `RISE_EN`, r7 `FALL_EN` RW: per-pin edge interrupt enables.
- r8 `IRQ_STAT` RW1C: sticky edge flags; writing 1 clears, writing 0 has no effect.
- Offsets 0x48..0xFF: read 0, writes ignored, still acked. Addresses outside the decode window: no ack, no effect.
- Bits at or above `NUM_IO` are unimplemented: read 0, writes discarded. A bank-1 access with `NUM_IO` <= 32 reads 0.
- Byte enables apply to every writable register, including SET/CLR/TGL/W1C: bits in disabled bytes are treated as 0.
- Edge detect: compare the last sync stage with a one-cycle-delayed copy. A rise with `RISE_EN` set, or a fall with `FALL_EN` set, sets the `IRQ_STAT` bit.
- If an edge-set and a W1C land on the same bit in the same cycle, set wins.
- Enables gate only new events; clearing an enable does not clear existing status.

## Timing
- Reset values: `io_out` = 0, `io_oeb` = all 1, `wbs_ack_o` = 0, `wbs_dat_o` = 0, `irq_o` = 0. All registers and synchroniser flops are 0, except `OEB` = all 1.
- Handshake: `wbs_ack_o` <= `stb & cyc & decode & ~wbs_ack_o`. Ack rises one edge after the request is seen, lasts exactly one cycle, and back-to-back requests ack every other cycle.
- Write commit and ack happen on the same edge; `io_out` / `io_oeb` change on that edge.
- Read data is registered on the same edge as ack and holds until the next read ack.
- Pin to `IN` visible: `SYNC_STAGES` edges. Pin edge to `IRQ_STAT` set: `SYNC_STAGES`+1 edges. `irq_o` follows one edge later.
- W1C to `irq_o` low: `irq_o` drops one edge after the write commit, if no other flags are set.
- Reset asserted mid-transaction: all state clears immediately and `wbs_ack_o` drops asynchronously. The master must reissue the access. Release of reset is synchronous to `wb_clk_i` through the standard reset synchroniser upstream.

## Test plan
- Reset, then read all registers -> `OEB` banks read 0xFFFFFFFF / 0x3F (NUM_IO=38); all others read 0; `io_oeb` = all 1; `irq_o` = 0.
- Write `OUT` bank0 = 0x000000AA, then `SET` bank0 = 0x00000100, `CLR` = 0x00000002, `TGL` = 0x00000081 -> `io_out[15:0]` = 0x0129; read `OUT` returns 0x00000129.
- Write `OUT` bank1 = 0xFFFFFFFF with `sel` = 4'b0001 -> `io_out[37:32]` = 6'h3F; bank1 read = 0x0000003F.
- Set `RISE_EN[3]`, drive `io_in[3]` 0->1 -> `IRQ_STAT[3]` sets 3 edges later (SYNC_STAGES=2) and `irq_o` = 1 one edge after; W1C 0x8 -> `irq_o` = 0.
- W1C bit 5 issued in the same cycle as a new enabled edge on pin 5 -> `IRQ_STAT[5]` stays 1.
- Assert `wb_rst_n_i` low during a read with ack pending -> ack = 0 immediately; after release, a reissued read completes with one-cycle ack. Access to offset 0x80 -> acked with data 0.
